// File: rtl/ddc_oct_accum_if.sv
// AXI-Stream style bundle (tdata/tvalid/tready) used for both the DDC input and the result output.
interface ddc_oct_accum_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/ddc_oct_accum.sv
// Frame integrator for the oct-DDC stream: sums N complex samples per frame into a result FIFO.
// Optional ACC_SEQ_EN adds a per-frame sequence number on m_axis_acc_tuser.
module ddc_oct_accum #(
  parameter int ACC_WIDTH  = 48,
  parameter int LOG2_MAX_N = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  ddc_oct_accum_if.slave        s_axis_ddc,
  input  logic [31:0]           cfg_n,
  input  logic                  cfg_valid,
  input  logic                  acc_en,
  ddc_oct_accum_if.master       m_axis_acc,
`ifdef ACC_SEQ_EN
  output logic [31:0]           m_axis_acc_tuser,
`endif
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ACC_SEQ_EN
  localparam int FW = 2*ACC_WIDTH + 32;
`else
  localparam int FW = 2*ACC_WIDTH;
`endif
  localparam logic [AW:0]         DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [LOG2_MAX_N:0] MAX_N   = {1'b1, {LOG2_MAX_N{1'b0}}};
  localparam logic [LOG2_MAX_N:0] ONE_N   = {{LOG2_MAX_N{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state, w_stateNext;
  logic                    w_seqClr;
  logic                    r_tready;
  logic [LOG2_MAX_N:0]     r_nPend, r_nAct, w_nClamp, w_nEff;
  logic [LOG2_MAX_N:0]     r_cnt;
  logic [ACC_WIDTH-1:0]    r_accI, r_accQ, r_resI, r_resQ;
  logic [ACC_WIDTH-1:0]    w_sampI, w_sampQ;
  logic                    r_resValid;
  logic                    w_beat, w_last;
  logic [FW-1:0]           w_pushData, w_head;
  logic [FW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wrPtr, r_rdPtr;
  logic [AW:0]             r_count;
  logic                    w_full, w_empty, w_push, w_pop, w_drop;
  logic [ACC_WIDTH-1:0]    w_headI, w_headQ;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) r_state <= S_IDLE;
    else               r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_seqClr    = 1'b0;
    case (r_state)
      S_IDLE: if (acc_en) begin
        w_stateNext = S_RUN;
        w_seqClr    = 1'b1;
      end
      S_RUN:  if (!acc_en) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_nClamp = cfg_n[LOG2_MAX_N:0];
    if (w_nClamp == '0)        w_nClamp = ONE_N;
    else if (w_nClamp > MAX_N) w_nClamp = MAX_N;
  end

  // A frame starting this beat already uses the pending length; r_nAct catches up on the same edge.
  assign w_nEff  = (r_cnt == '0) ? r_nPend : r_nAct;
  assign w_beat  = s_axis_ddc.tvalid && r_tready;
  assign w_last  = w_beat && acc_en && (r_cnt == (w_nEff - 1'b1));
  assign w_sampI = {{(ACC_WIDTH-30){s_axis_ddc.tdata[29]}}, s_axis_ddc.tdata[29:0]};
  assign w_sampQ = {{(ACC_WIDTH-30){s_axis_ddc.tdata[61]}}, s_axis_ddc.tdata[61:32]};
  assign s_axis_ddc.tready = r_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_tready   <= 1'b0;
      r_nPend    <= ONE_N;
      r_nAct     <= ONE_N;
      r_cnt      <= '0;
      r_accI     <= '0;
      r_accQ     <= '0;
      r_resI     <= '0;
      r_resQ     <= '0;
      r_resValid <= 1'b0;
    end else begin
      r_tready   <= 1'b1;
      r_resValid <= w_last;
      if (cfg_valid)    r_nPend <= w_nClamp;
      if (r_cnt == '0)  r_nAct  <= r_nPend;
      if (!acc_en) begin
        r_accI <= '0;
        r_accQ <= '0;
        r_cnt  <= '0;
      end else if (w_last) begin
        r_resI <= r_accI + w_sampI;
        r_resQ <= r_accQ + w_sampQ;
        r_accI <= '0;
        r_accQ <= '0;
        r_cnt  <= '0;
      end else if (w_beat) begin
        r_accI <= r_accI + w_sampI;
        r_accQ <= r_accQ + w_sampQ;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef ACC_SEQ_EN
  logic [31:0] r_seq, r_resSeq, w_seqCur;

  // Dropped frames still consume a number so the sink can spot gaps.
  assign w_seqCur = w_seqClr ? 32'd0 : r_seq;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_seq    <= '0;
      r_resSeq <= '0;
    end else if (w_last) begin
      r_resSeq <= w_seqCur;
      r_seq    <= w_seqCur + 32'd1;
    end else if (w_seqClr) begin
      r_seq    <= '0;
    end
  end

  assign w_pushData       = {r_resSeq, r_resQ, r_resI};
  assign m_axis_acc_tuser = w_empty ? 32'd0 : w_head[FW-1:2*ACC_WIDTH];
  logic w_unused;
  assign w_unused = &{1'b0, s_axis_ddc.tdata[63:62], s_axis_ddc.tdata[31:30],
                      cfg_n[31:LOG2_MAX_N+1]};
`else
  assign w_pushData = {r_resQ, r_resI};
  logic w_unused;
  assign w_unused = &{1'b0, s_axis_ddc.tdata[63:62], s_axis_ddc.tdata[31:30],
                      cfg_n[31:LOG2_MAX_N+1], w_seqClr};
`endif

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && m_axis_acc.tready;
  assign w_push  = r_resValid && (!w_full || w_pop);
  assign w_drop  = r_resValid && !w_push;

  always_ff @(posedge s_axis_aclk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushData;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, restarting the count at one.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (overflow_clr)              drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign w_head            = r_mem[r_rdPtr];
  assign w_headI           = w_head[ACC_WIDTH-1:0];
  assign w_headQ           = w_head[2*ACC_WIDTH-1:ACC_WIDTH];
  assign m_axis_acc.tvalid = !w_empty;
  assign m_axis_acc.tdata  = w_empty ? 128'd0 :
                             {{(64-ACC_WIDTH){w_headQ[ACC_WIDTH-1]}}, w_headQ,
                              {(64-ACC_WIDTH){w_headI[ACC_WIDTH-1]}}, w_headI};

endmodule
